// File: rtl/axi_rd_burst_split.sv
// axi_rd_burst_split: splits one AXI4 read burst (clk, rst, s_axi_ar*/r* slave side, m_axi_ar*/r* master side) into sub-bursts of at most MAX_BURST_LEN beats, re-framing RLAST
module axi_rd_burst_split #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 8,
  parameter bit ARUSER_ENABLE = 0,
  parameter int ARUSER_WIDTH  = 1,
  parameter bit RUSER_ENABLE  = 0,
  parameter int RUSER_WIDTH   = 1,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam logic [8:0] MAX = 9'(MAX_BURST_LEN);
  localparam logic [1:0] WRAP = 2'b10;
  localparam logic [1:0] INCR = 2'b01;
  state_t r_state, w_next;
  logic r_arready;
  logic [ID_WIDTH-1:0] r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic r_lock;
  logic [3:0] r_cache, r_qos, r_region;
  logic [2:0] r_prot;
  logic [ARUSER_WIDTH-1:0] r_user;
  logic [8:0] r_ar_left, r_r_left, w_beats, w_r_left_nxt;
  logic w_s_hs, w_m_hs, w_r_hs, w_unused;
  assign w_s_hs = s_axi_arvalid & r_arready;
  assign w_m_hs = (r_state == ISSUE) & m_axi_arready;
  assign w_r_hs = m_axi_rvalid & s_axi_rready;
  // WRAP bursts go out whole; they are at most 16 beats so this only guards odd inputs
  assign w_beats = (r_burst == WRAP || r_ar_left <= MAX) ? r_ar_left : MAX;
  assign w_r_left_nxt = (w_r_hs && r_r_left != 9'd0) ? r_r_left - 9'd1 : r_r_left;
  assign w_unused = m_axi_rlast;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_s_hs ? ISSUE : IDLE;
      ISSUE:   w_next = (w_m_hs && r_ar_left == w_beats) ? DRAIN : ISSUE;
      // Leave as soon as the final beat handshakes so arready returns one cycle later
      DRAIN:   w_next = (w_r_left_nxt == 9'd0) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_arready <= 1'b0;
      r_ar_left <= 9'd0;
      r_r_left  <= 9'd0;
    end else begin
      r_state   <= w_next;
      r_arready <= (w_next == IDLE);
      r_r_left  <= w_s_hs ? {1'b0, s_axi_arlen} + 9'd1 : w_r_left_nxt;
      if (w_s_hs) begin
        r_ar_left <= {1'b0, s_axi_arlen} + 9'd1;
        r_addr    <= s_axi_araddr;
      end else if (w_m_hs) begin
        r_ar_left <= r_ar_left - w_beats;
        if (r_burst == INCR) r_addr <= r_addr + (ADDR_WIDTH'(w_beats) << r_size);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_id     <= s_axi_arid;
      r_size   <= s_axi_arsize;
      r_burst  <= s_axi_arburst;
      r_lock   <= s_axi_arlock;
      r_cache  <= s_axi_arcache;
      r_prot   <= s_axi_arprot;
      r_qos    <= s_axi_arqos;
      r_region <= s_axi_arregion;
      r_user   <= s_axi_aruser;
    end
  end
  assign s_axi_arready  = r_arready;
  assign m_axi_arvalid  = (r_state == ISSUE);
  assign m_axi_arid     = r_id;
  assign m_axi_araddr   = r_addr;
  assign m_axi_arlen    = 8'(w_beats - 9'd1);
  assign m_axi_arsize   = r_size;
  assign m_axi_arburst  = r_burst;
  assign m_axi_arlock   = r_lock;
  assign m_axi_arcache  = r_cache;
  assign m_axi_arprot   = r_prot;
  assign m_axi_arqos    = r_qos;
  assign m_axi_arregion = r_region;
  assign m_axi_aruser   = ARUSER_ENABLE ? r_user : '0;
  assign s_axi_rvalid   = m_axi_rvalid;
  assign m_axi_rready   = s_axi_rready;
  assign s_axi_rid      = m_axi_rid;
  assign s_axi_rdata    = m_axi_rdata;
  assign s_axi_rresp    = m_axi_rresp;
  assign s_axi_ruser    = RUSER_ENABLE ? m_axi_ruser : '0;
  assign s_axi_rlast    = (r_r_left == 9'd1);
endmodule

// File: doc/axi_rd_burst_split.md
# axi_rd_burst_split

AXI4 read-channel burst splitter placed directly upstream of the read-data FIFO on the master side. It accepts one read burst of up to 256 beats and reissues it as a sequence of sub-bursts no longer than MAX_BURST_LEN. This keeps every burst reaching the FIFO within its depth, so delayed-AR operation never stalls on an oversized burst. Returned R beats pass through unchanged except RLAST, which is asserted only on the final beat of the original burst.

## Interface
- DATA_WIDTH, 32, R data width
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 8, ARID/RID width
- ARUSER_ENABLE, 0, propagate aruser; when 0, m_axi_aruser is driven to 0
- ARUSER_WIDTH, 1, aruser width
- RUSER_ENABLE, 0, propagate ruser; when 0, s_axi_ruser is driven to 0
- RUSER_WIDTH, 1, ruser width
- MAX_BURST_LEN, 16, maximum sub-burst length in beats; legal range 16..256
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  slave AR fields
- s_axi_arlock/arcache/arprot/arqos/arregion/aruser  in  1/4/3/4/4/ARUSER_WIDTH  slave AR sideband
- s_axi_arvalid  in  1;  s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast/ruser  out  ID_WIDTH/DATA_WIDTH/2/1/RUSER_WIDTH  slave R channel
- s_axi_rvalid  out  1;  s_axi_rready  in  1
- m_axi_ar*  out  same widths as s_axi_ar*  master AR channel (registered)
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rid/rdata/rresp/rlast/ruser  in  same widths  master R channel
- m_axi_rvalid  in  1;  m_axi_rready  out  1

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE**
  - s_axi_arready=1.
  - On AR handshake, capture all AR fields, set ar_beats_left=arlen+1 (9 bits) and r_beats_left=arlen+1, then go to ISSUE.
- **ISSUE**
  - Drive m_axi_arvalid=1 with sub_len = min(ar_beats_left, MAX_BURST_LEN)-1. All other AR fields are the captured values; the current address is on m_axi_araddr.
  - On m_axi_arready:
    - ar_beats_left -= sub_len+1.
    - If arburst==INCR, address += (sub_len+1)<<arsize, truncated to ADDR_WIDTH.
    - If arburst==FIXED, address is unchanged.
    - If ar_beats_left reaches 0, go to DRAIN; otherwise load the next sub-burst on the following cycle.
- **WRAP bursts**: never split. They are issued once with the original arlen (always ≤15, so they fit).
- **DRAIN**: wait until r_beats_left==0, then go to IDLE.
  - R beats may already flow while in ISSUE; DRAIN only covers the remainder.
- **R channel**: combinational pass-through.
  - s_axi_rvalid=m_axi_rvalid, m_axi_rready=s_axi_rready.
  - rid, rdata, rresp and ruser pass unchanged.
  - On each R handshake, r_beats_left decrements.
  - s_axi_rlast = (r_beats_left==1). m_axi_rlast is ignored for slave-side framing.
- Exactly one original burst is outstanding at a time; s_axi_arready stays 0 from acceptance until the last R beat has been handshaken.
- No 4 KB check is performed. A legal original burst cannot cross 4 KB, so its sub-bursts cannot either.

## Timing
- Reset values:
  - s_axi_arready=0; it rises on the first cycle after rst deasserts.
  - m_axi_arvalid=0; FSM=IDLE; both beat counters=0.
- AR latency: s_axi handshake in cycle N gives m_axi_arvalid=1 in N+1. Consecutive sub-bursts issue back-to-back, one per cycle, if m_axi_arready stays high.
- m_axi_ar* fields are stable while m_axi_arvalid=1 and m_axi_arready=0.
- R path adds zero cycles of latency.
- Next s_axi_arready=1 comes at the earliest one cycle after the final R handshake.
- An R handshake in the same cycle as the last sub-burst AR handshake is counted; the FSM still passes through DRAIN.
- rst asserted mid-burst aborts everything next cycle. Outstanding downstream beats are not tracked; the system resets both sides together.

## Test plan
- INCR, araddr=0x1000, arsize=2, arlen=39, MAX=16 -> three m_axi ARs: (0x1000, len 15), (0x1040, len 15), (0x1080, len 7). 40 R beats; s_axi_rlast only on beat 40, even though m_axi_rlast pulses on beats 16, 32 and 40.
- INCR arlen=7 -> single AR with len 7, identical fields; rlast on beat 8; next arready 1 cycle later.
- WRAP arlen=15, araddr=0x2030 -> one AR, unsplit, address unchanged.
- FIXED arlen=20, araddr=0x3000 -> ARs len 15 and len 4, both at 0x3000; rlast on beat 21.
- m_axi_arready held low 5 cycles and s_axi_rready toggled every cycle -> m_axi_ar fields stable while stalled; no beat lost or duplicated; count correct.
- rst pulsed mid-ISSUE of arlen=255 -> m_axi_arvalid=0 and s_axi_arready=0 next cycle, arready=1 the cycle after; a new arlen=0 burst then completes normally.
